// File: rtl/gshare_btb_predictor.sv
// Gshare direction predictor merged with a direct-mapped BTB; lookup is combinational, update commits on the clock edge.
// Latency: zero-cycle lookup, one-edge update. No backpressure: the parent holds lk_pc4 across stalls.
module gshare_btb_predictor #(
    parameter int IDX_BITS  = 4,
    parameter int GHR_BITS  = 2,
    parameter int STAT_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          lk_pc4,
    output logic                 lk_hit,
    output logic                 lk_taken,
    output logic [31:0]          lk_target,
    output logic [IDX_BITS-1:0]  lk_idx,
    input  logic                 upd_valid,
    input  logic [IDX_BITS-1:0]  upd_idx,
    input  logic [31:0]          upd_pc4,
    input  logic                 upd_taken,
    input  logic [31:0]          upd_target,
    input  logic                 upd_mispredict,
    output logic [GHR_BITS-1:0]  ghr,
    output logic [STAT_BITS-1:0] stat_branches,
    output logic [STAT_BITS-1:0] stat_mispredicts
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = 30 - IDX_BITS;

    logic                 valid_q [ENTRIES];
    logic [TAG_W-1:0]     tag_q   [ENTRIES];
    logic [31:0]          tgt_q   [ENTRIES];
    logic [1:0]           ctr_q   [ENTRIES];
    logic [GHR_BITS-1:0]  ghr_q, ghr_d;
    logic [STAT_BITS-1:0] br_q, br_d;
    logic [STAT_BITS-1:0] mp_q, mp_d;

    logic [TAG_W-1:0]     lk_tag;
    logic [TAG_W-1:0]     upd_tag;
    logic                 upd_hit;
    logic [1:0]           ent_ctr;
    logic [1:0]           ctr_d;
    logic                 wr_alloc;
    logic                 wr_ctr;
    logic                 wr_tgt;
    logic                 unused_pc_lsbs;

    assign unused_pc_lsbs = ^{lk_pc4[1:0], upd_pc4[1:0]};

    // Lookup sees only registered state, so a same-cycle update is invisible until the next cycle.
    assign lk_tag    = lk_pc4[31:IDX_BITS+2];
    assign lk_idx    = lk_pc4[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);
    assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken  = lk_hit && ctr_q[lk_idx][1];
    assign lk_target = tgt_q[lk_idx];

    assign upd_tag = upd_pc4[31:IDX_BITS+2];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign ent_ctr = ctr_q[upd_idx];

    always_comb begin
        wr_alloc = 1'b0;
        wr_ctr   = 1'b0;
        wr_tgt   = 1'b0;
        ctr_d    = ent_ctr;
        if (upd_valid) begin
            if (upd_hit) begin
                wr_ctr = 1'b1;
                wr_tgt = upd_taken;
                if (upd_taken) begin
                    ctr_d = (ent_ctr == 2'b11) ? 2'b11 : ent_ctr + 2'b01;
                end else begin
                    ctr_d = (ent_ctr == 2'b00) ? 2'b00 : ent_ctr - 2'b01;
                end
            end else if (upd_taken) begin
                // Only taken branches earn an entry; a not-taken miss behaves like fall-through anyway.
                wr_alloc = 1'b1;
                wr_ctr   = 1'b1;
                wr_tgt   = 1'b1;
                ctr_d    = 2'b10;
            end
        end
    end

    always_comb begin
        ghr_d = ghr_q;
        br_d  = br_q;
        mp_d  = mp_q;
        if (upd_valid) begin
            ghr_d = GHR_BITS'({ghr_q, upd_taken});
            if (!(&br_q)) begin
                br_d = br_q + 1'b1;
            end
            if (upd_mispredict && !(&mp_q)) begin
                mp_d = mp_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= 2'b01;
            end
        end else begin
            if (wr_alloc) begin
                valid_q[upd_idx] <= 1'b1;
                tag_q[upd_idx]   <= upd_tag;
            end
            if (wr_ctr) begin
                ctr_q[upd_idx] <= ctr_d;
            end
            if (wr_tgt) begin
                tgt_q[upd_idx] <= upd_target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q <= '0;
            br_q  <= '0;
            mp_q  <= '0;
        end else begin
            ghr_q <= ghr_d;
            br_q  <= br_d;
            mp_q  <= mp_d;
        end
    end

    assign ghr              = ghr_q;
    assign stat_branches    = br_q;
    assign stat_mispredicts = mp_q;
endmodule
